imem_boot_loader: RTL and testbench

//  Upstream feeder for the 16-bit single-cycle processor: receives a program image as a byte

---
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 tb/tb_imem_boot_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes 16-bit words into instruction
// memory and releases the processor only after the image checksum matches.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS      = 256,
    parameter logic [15:0] BASE_ADDR      = 16'h0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);
    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     len_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      csum_q;
    logic [7:0]      hi_q;
    logic [TW-1:0]   tmo_q;
    logic            rx_state, accept, restart, tmo_expired;
    logic [15:0]     len_rx;

    assign rx_state    = (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
    assign in_ready    = rx_state;
    assign accept      = in_valid && rx_state;
    assign restart     = start && (state_q == S_DONE || state_q == S_ERR);
    assign len_rx      = {len_q[15:8], in_data};
    // The counter saturates one short of the limit; the idle cycle that would reach it aborts.
    assign tmo_expired = (TIMEOUT_CYCLES > 0) && rx_state && !accept && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_LEN_HI;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        imem_we    = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state_q)
            S_LEN_HI:  if (accept) state_d = S_LEN_LO;
            S_LEN_LO:  if (accept)
                           state_d = (len_rx == 16'd0 || {1'b0, len_rx} > 17'(MAX_WORDS))
                                     ? S_ERR : S_DATA_HI;
            S_DATA_HI: if (accept) state_d = S_DATA_LO;
            S_DATA_LO: if (accept) state_d = S_WRITE;
            S_WRITE: begin
                imem_we = 1'b1;
                state_d = ({1'b0, len_q} == 17'(idx_q) + 17'd1) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM:    if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            S_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            S_ERR: begin
                load_error = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default:   state_d = S_LEN_HI;
        endcase
        if (tmo_expired) state_d = S_ERR;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            hi_q       <= '0;
            tmo_q      <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_LEN_HI:  len_q[15:8] <= in_data;
                    S_LEN_LO:  len_q[7:0]  <= in_data;
                    S_DATA_HI: begin
                        hi_q   <= in_data;
                        csum_q <= csum_q + in_data;
                    end
                    S_DATA_LO: begin
                        csum_q     <= csum_q + in_data;
                        imem_addr  <= BASE_ADDR + 16'({idx_q, 1'b0});
                        imem_wdata <= {hi_q, in_data};
                    end
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) idx_q <= idx_q + 1'b1;
            if (restart) begin
                idx_q  <= '0;
                csum_q <= '0;
            end
            if (TIMEOUT_CYCLES == 0 || accept || !rx_state || state_d != state_q)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table-driven images plus hand-written sequences for
// gaps, mid-load reset, N==MAX_WORDS and the timeout variant.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, sel;
    logic [7:0]  in_data;
    logic        r0, we0, h0, d0, e0, r1, we1, h1, d1, e1;
    logic [15:0] a0, w0, a1, w1;

    imem_boot_loader dut0 (
        .clk(clk), .reset(reset), .start(start & ~sel), .in_data(in_data),
        .in_valid(in_valid & ~sel), .in_ready(r0), .imem_we(we0), .imem_addr(a0),
        .imem_wdata(w0), .cpu_hold(h0), .load_done(d0), .load_error(e0)
    );

    imem_boot_loader #(.TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .reset(reset), .start(start & sel), .in_data(in_data),
        .in_valid(in_valid & sel), .in_ready(r1), .imem_we(we1), .imem_addr(a1),
        .imem_wdata(w1), .cpu_hold(h1), .load_done(d1), .load_error(e1)
    );

    wire        cur_ready = sel ? r1 : r0;
    wire        cur_we    = sel ? we1 : we0;
    wire [15:0] cur_addr  = sel ? a1 : a0;
    wire [15:0] cur_wdata = sel ? w1 : w0;
    wire        cur_hold  = sel ? h1 : h0;
    wire        cur_done  = sel ? d1 : d0;
    wire        cur_err   = sel ? e1 : e0;

    int checks = 0;
    int errors = 0;
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];

    // Each negedge with imem_we high is one write; a stretched strobe shows up as a duplicate.
    always @(negedge clk) begin
        if (cur_we === 1'b1) begin
            wr_addr.push_back(cur_addr);
            wr_data.push_back(cur_wdata);
        end
    end

    typedef struct {
        logic [63:0] bytes;      // image bytes, left-justified, byte 0 in [63:56]
        int          nbytes;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one byte (after an optional idle gap) and returns one tick after it is accepted.
    // in_valid is left high so a following byte keeps it asserted through WRITE.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bit rdy;
            rdy = cur_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%0h", b);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [63:0] w, input int i);
        return w[63-8*i -: 8];
    endfunction

    task automatic check_writes(input string tag, input vec_t v);
        check({tag, "_wr_count"}, wr_addr.size(), v.exp_writes);
        for (int k = 0; k < v.exp_writes && k < wr_addr.size(); k++) begin
            check({tag, "_wr_addr"}, wr_addr[k], 2 * k);
            check({tag, "_wr_data"}, wr_data[k],
                  {get_byte(v.bytes, 2 + 2*k), get_byte(v.bytes, 3 + 2*k)});
        end
    endtask

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h0002_1234_ABCD_BE00, 7, 1'b1, 1'b0, 2};  // good image
        vecs[1] = '{64'h0002_1234_ABCD_BF00, 7, 1'b0, 1'b1, 2};  // bad checksum
        vecs[2] = '{64'h0000_0000_0000_0000, 2, 1'b0, 1'b1, 0};  // N == 0
        vecs[3] = '{64'h0101_0000_0000_0000, 2, 1'b0, 1'b1, 0};  // N == MAX_WORDS + 1
        vecs[4] = '{64'h0001_FFFF_FE00_0000, 5, 1'b1, 1'b0, 1};  // N == 1, checksum wraps

        sel = 1'b0;
        do_reset();
        check("rst_ready", cur_ready, 1);
        check("rst_we",    cur_we,    0);
        check("rst_addr",  cur_addr,  0);
        check("rst_wdata", cur_wdata, 0);
        check("rst_hold",  cur_hold,  1);
        check("rst_done",  cur_done,  0);
        check("rst_err",   cur_err,   0);

        for (int v = 0; v < 5; v++) begin
            string tag = $sformatf("vec%0d", v);
            do_reset();
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(get_byte(vecs[v].bytes, i), 0);
                if (i >= 3 && (i % 2) == 1 && i < 2 + 2 * vecs[v].exp_writes) begin
                    check({tag, "_we_latency"}, cur_we, 1);
                    check({tag, "_we_addr"}, cur_addr, i - 3);
                    check({tag, "_we_data"}, cur_wdata,
                          {get_byte(vecs[v].bytes, i - 1), get_byte(vecs[v].bytes, i)});
                end
            end
            in_valid = 1'b0;
            check({tag, "_done"}, cur_done, vecs[v].exp_done);
            check({tag, "_err"},  cur_err,  vecs[v].exp_err);
            check({tag, "_hold"}, cur_hold, !vecs[v].exp_done);
            tick();
            tick();
            check_writes(tag, vecs[v]);
            if (v == 0) begin
                check("hold_we",    cur_we,    0);
                check("hold_addr",  cur_addr,  16'h0002);
                check("hold_wdata", cur_wdata, 16'hABCD);
            end
        end

        // N == MAX_WORDS: word k = 0x00kk, checksum = sum(0..255) mod 256 = 0x80.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'h00, 0);
            send_byte(8'(k), 0);
        end
        send_byte(8'h80, 0);
        in_valid = 1'b0;
        check("max_done", cur_done, 1);
        tick();
        check("max_wr_count", wr_addr.size(), 256);
        if (wr_addr.size() == 256) begin
            check("max_last_addr", wr_addr[255], 16'h01FE);
            check("max_last_data", wr_data[255], 16'h00FF);
        end

        // Random gaps, with in_valid kept high through both WRITE cycles.
        do_reset();
        for (int i = 0; i < vecs[0].nbytes; i++)
            send_byte(get_byte(vecs[0].bytes, i), (i == 4 || i == 6) ? 0 : $urandom_range(0, 3));
        in_valid = 1'b0;
        tick();
        tick();
        check("gap_done", cur_done, 1);
        check_writes("gap", vecs[0]);

        // Restart from DONE, then async reset between DATA_HI and DATA_LO.
        pulse_start();
        check("restart_hold", cur_hold, 1);
        check("restart_done", cur_done, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_ready", cur_ready, 1);
        check("async_we",    cur_we,    0);
        check("async_addr",  cur_addr,  0);
        check("async_wdata", cur_wdata, 0);
        check("async_hold",  cur_hold,  1);
        check("async_done",  cur_done,  0);
        check("async_err",   cur_err,   0);
        tick();
        reset = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < vecs[0].nbytes; i++) send_byte(get_byte(vecs[0].bytes, i), 0);
        in_valid = 1'b0;
        tick();
        tick();
        check("post_rst_done", cur_done, 1);
        check_writes("post_rst", vecs[0]);

        // Timeout variant: 16 idle cycles in DATA_HI abort the load.
        sel = 1'b1;
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        in_valid = 1'b0;
        repeat (15) tick();
        check("tmo_15_err", cur_err, 0);
        tick();
        check("tmo_16_err",  cur_err,  1);
        check("tmo_16_hold", cur_hold, 1);
        pulse_start();
        check("tmo_restart_err",   cur_err,   0);
        check("tmo_restart_ready", cur_ready, 1);
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < vecs[0].nbytes; i++) send_byte(get_byte(vecs[0].bytes, i), 0);
        in_valid = 1'b0;
        check("tmo_reload_done", cur_done, 1);
        check("tmo_reload_hold", cur_hold, 0);
        tick();
        tick();
        check_writes("tmo_reload", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
